// File: rtl/cdr_os.sv
// Oversampling clock-data recovery: synchronizes the raw serial line, realigns phase on each
// transition, samples one bit per OSR clocks, grades transitions and tracks lock.
module cdr_os #(
  parameter int OSR         = 4,
  parameter int SYNC_STAGES = 3,
  parameter int SAMPLE_PH   = 1,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_ERR  = 4,
  parameter int MAX_RUN     = 16,
  parameter int ERRW        = 16
) (
  input  logic            i_clk,
  input  logic            i_res_n,
  input  logic            i_SerialData,
  input  logic            i_err_clr,
  output logic            o_RecoveryData,
  output logic            o_DataEn,
  output logic            o_err,
  output logic            o_timeout,
  output logic            o_locked,
  output logic [ERRW-1:0] o_err_cnt
);

  localparam int TOP  = SYNC_STAGES - 1;
  localparam int PHW  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int RUNW = $clog2(MAX_RUN + 1);
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int LVW  = $clog2(UNLOCK_ERR + 1);

  localparam logic [PHW-1:0]  PH_LAST   = PHW'(OSR - 1);
  localparam logic [PHW-1:0]  PH_SAMPLE = PHW'(SAMPLE_PH);
  localparam logic [PHW-1:0]  PH_EARLY  = PHW'(OSR - 1 - TOL);
  localparam logic [PHW-1:0]  PH_LATE   = PHW'(TOL);
  localparam logic [RUNW-1:0] RUN_MAX   = RUNW'(MAX_RUN);
  localparam logic [RUNW-1:0] RUN_LAST  = RUNW'(MAX_RUN - 1);
  localparam logic [GW-1:0]   G_LAST    = GW'(LOCK_CNT - 1);
  localparam logic [LVW-1:0]  LV_LAST   = LVW'(UNLOCK_ERR - 1);

  typedef enum logic {ACQ, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ts_q;
  logic [PHW-1:0]         ph;
  logic [RUNW-1:0]        run_cnt;
  state_t                 state;
  logic [GW-1:0]          gcnt;
  logic [LVW-1:0]         lvl;

  logic ts, sample_now, in_win, bad_ts, good_ts, timeout_now;

  // NOTE: combinational terms are continuous assigns, so no path can be left unassigned and infer a latch.
  assign ts          = sync_q[TOP] ^ sync_q[TOP-1];
  assign sample_now  = (ph == PH_SAMPLE);
  assign in_win      = (ph >= PH_EARLY) || (ph < PH_LATE);
  // A transition right after another one is a glitch, whatever the phase says.
  assign bad_ts      = ts && (!in_win || ts_q);
  assign good_ts     = ts && !bad_ts;
  assign timeout_now = !ts && sample_now && (run_cnt == RUN_LAST);

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      sync_q         <= '0;
      ts_q           <= 1'b0;
      ph             <= '0;
      run_cnt        <= '0;
      o_RecoveryData <= 1'b0;
      o_DataEn       <= 1'b0;
      o_err          <= 1'b0;
      o_timeout      <= 1'b0;
      o_err_cnt      <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_SerialData};
      ts_q   <= ts;

      if (ts || ph == PH_LAST) ph <= '0;
      else                     ph <= ph + PHW'(1);

      o_DataEn <= sample_now;
      if (sample_now) o_RecoveryData <= sync_q[TOP];

      o_err     <= bad_ts;
      o_timeout <= timeout_now;

      // Holds at MAX_RUN after a timeout so the pulse fires only once per run.
      if (ts)                                  run_cnt <= '0;
      else if (sample_now && run_cnt != RUN_MAX) run_cnt <= run_cnt + RUNW'(1);

      if (i_err_clr)                 o_err_cnt <= '0;
      else if (o_err && ~&o_err_cnt) o_err_cnt <= o_err_cnt + ERRW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state    <= ACQ;
      gcnt     <= '0;
      lvl      <= '0;
      o_locked <= 1'b0;
    end else begin
      o_locked <= (state == LOCKED);
      case (state)
        ACQ: begin
          if (good_ts) begin
            if (gcnt == G_LAST) begin
              state <= LOCKED;
              gcnt  <= '0;
              lvl   <= '0;
            end else begin
              gcnt <= gcnt + GW'(1);
            end
          end else if (bad_ts || timeout_now) begin
            gcnt <= '0;
          end
        end
        LOCKED: begin
          if (timeout_now) begin
            state <= ACQ;
            gcnt  <= '0;
            lvl   <= '0;
          end else if (bad_ts) begin
            if (lvl == LV_LAST) begin
              state <= ACQ;
              gcnt  <= '0;
              lvl   <= '0;
            end else begin
              lvl <= lvl + LVW'(1);
            end
          end else if (good_ts && lvl != '0) begin
            lvl <= lvl - LVW'(1);
          end
        end
        default: state <= ACQ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdr_os.sv
// Bench for cdr_os: input is described as a list of transition gaps; expected strobes, errors,
// timeouts, lock and error count are derived per cycle from those gaps.
module tb_cdr_os;

  localparam int OSR        = 4;
  localparam int SAMPLE_PH  = 1;
  localparam int TOL        = 1;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_ERR = 4;
  localparam int MAX_RUN    = 16;
  localparam int ERRW       = 16;
  localparam int MAXC       = 4096;

  logic            i_clk = 1'b0;
  logic            i_res_n = 1'b0;
  logic            i_SerialData = 1'b0;
  logic            i_err_clr = 1'b0;
  logic            o_RecoveryData, o_DataEn, o_err, o_timeout, o_locked;
  logic [ERRW-1:0] o_err_cnt;

  cdr_os dut (
    .i_clk          (i_clk),
    .i_res_n        (i_res_n),
    .i_SerialData   (i_SerialData),
    .i_err_clr      (i_err_clr),
    .o_RecoveryData (o_RecoveryData),
    .o_DataEn       (o_DataEn),
    .o_err          (o_err),
    .o_timeout      (o_timeout),
    .o_locked       (o_locked),
    .o_err_cnt      (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit exp_en [MAXC];
  bit exp_dat[MAXC];
  bit exp_err[MAXC];
  bit exp_to [MAXC];
  bit exp_lock[MAXC];
  int exp_cnt[MAXC];
  bit din    [MAXC];
  int ev     [MAXC];   // 0 none, 1 good edge, 2 bad edge, 3 timeout

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_res_n      = 1'b0;
    i_SerialData = 1'b0;
    i_err_clr    = 1'b0;
    #1;
    check("rst.data",   o_RecoveryData, 0);
    check("rst.en",     o_DataEn,       0);
    check("rst.err",    o_err,          0);
    check("rst.to",     o_timeout,      0);
    check("rst.locked", o_locked,       0);
    check("rst.cnt",    o_err_cnt,      0);
    repeat (2) @(posedge i_clk);
    #1 i_res_n = 1'b1;
  endtask

  // lens[i] is the gap in clocks before input change i (lens[0] from reset release);
  // the last level is then held for tail clocks. Level toggles at every change.
  task automatic run_sched(input string name, input int lens[$], input int tail, output int n_to);
    int chg[$];
    int m, n_cyc, p, q, len, last, cnt, ph, idx, st, gcnt, lv;
    bit lvl, cur, bad;
    m = 0;
    n_to = 0;
    foreach (lens[i]) begin
      m += lens[i];
      chg.push_back(m);
    end
    n_cyc = m + tail;
    if (n_cyc + 2 > MAXC) begin
      $display("FAIL %s: schedule of %0d cycles exceeds %0d", name, n_cyc, MAXC);
      $fatal(1);
    end
    for (int c = 0; c < n_cyc + 2; c++) begin
      exp_en[c] = 0; exp_dat[c] = 0; exp_err[c] = 0; exp_to[c] = 0;
      exp_lock[c] = 0; exp_cnt[c] = 0; ev[c] = 0;
    end
    idx = 0;
    cur = 0;
    for (int c = 0; c < n_cyc; c++) begin
      while (idx < chg.size() && chg[idx] == c) begin
        cur = ~cur;
        idx++;
      end
      din[c] = cur;
    end
    // A change driven in cycle m is seen as a transition in cycle m+2; reset acts as a
    // virtual transition in cycle -1 since the phase starts at 0 in cycle 0.
    p = -1;
    for (int j = 0; j <= chg.size(); j++) begin
      lvl = bit'(j % 2);
      if (j < chg.size()) begin
        q = chg[j] + 2;
        len = q - p;
        last = len;
      end else begin
        len = 0;
        last = n_cyc - 1 - p;
      end
      cnt = 0;
      for (int k = 1; k <= last; k++) begin
        ph = (k - 1) % OSR;
        if (ph == SAMPLE_PH) begin
          exp_en[p + k + 1]  = 1;
          exp_dat[p + k + 1] = lvl;
          if (j == chg.size() || k < len) begin
            cnt++;
            if (cnt == MAX_RUN) begin
              exp_to[p + k + 1] = 1;
              ev[p + k] = 3;
            end
          end
        end
      end
      if (j < chg.size()) begin
        ph  = (len - 1) % OSR;
        bad = !((ph >= OSR - 1 - TOL) || (ph < TOL)) || (len == 1);
        exp_err[q + 1] = bad;
        ev[q] = bad ? 2 : 1;
        p = q;
      end
    end
    st = 0; gcnt = 0; lv = 0;
    for (int c = 0; c < n_cyc; c++) begin
      exp_lock[c + 1] = bit'(st);
      if (st == 0) begin
        if (ev[c] == 1) begin
          if (gcnt == LOCK_CNT - 1) begin st = 1; gcnt = 0; lv = 0; end
          else gcnt++;
        end else if (ev[c] == 2 || ev[c] == 3) begin
          gcnt = 0;
        end
      end else begin
        if (ev[c] == 3) begin
          st = 0; gcnt = 0;
        end else if (ev[c] == 2) begin
          lv++;
          if (lv >= UNLOCK_ERR) begin st = 0; gcnt = 0; lv = 0; end
        end else if (ev[c] == 1 && lv > 0) begin
          lv--;
        end
      end
      exp_cnt[c + 1] = (exp_err[c] && exp_cnt[c] < (1 << ERRW) - 1) ? exp_cnt[c] + 1 : exp_cnt[c];
    end

    do_reset();
    for (int c = 0; c < n_cyc; c++) begin
      i_SerialData = din[c];
      @(negedge i_clk);
      check($sformatf("%s.en@%0d", name, c), o_DataEn, exp_en[c]);
      if (exp_en[c]) check($sformatf("%s.data@%0d", name, c), o_RecoveryData, exp_dat[c]);
      check($sformatf("%s.err@%0d", name, c), o_err, exp_err[c]);
      check($sformatf("%s.to@%0d", name, c), o_timeout, exp_to[c]);
      check($sformatf("%s.locked@%0d", name, c), o_locked, exp_lock[c]);
      check($sformatf("%s.cnt@%0d", name, c), o_err_cnt, exp_cnt[c]);
      n_to += int'(o_timeout);
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic void push_n(ref int q[$], input int gap, input int n);
    for (int i = 0; i < n; i++) q.push_back(gap);
  endfunction

  initial begin
    int l[$];
    int n_to, total, r, g;

    // Clean 1010 pattern: lock on the 16th transition, no errors.
    l = {5}; push_n(l, 4, 39);
    run_sched("clean", l, 8, n_to);
    check("clean.locked_end", o_locked, 1);
    check("clean.cnt_end", o_err_cnt, 0);

    // Early edge in ACQ restarts the good count: 15 goods afterwards is one short of lock.
    l = {5}; push_n(l, 4, 8); l.push_back(2); push_n(l, 4, 15);
    run_sched("acq_early15", l, 8, n_to);
    check("acq_early15.locked_end", o_locked, 0);
    check("acq_early15.cnt_end", o_err_cnt, 1);
    l = {5}; push_n(l, 4, 8); l.push_back(2); push_n(l, 4, 16);
    run_sched("acq_early16", l, 8, n_to);
    check("acq_early16.locked_end", o_locked, 1);

    // Early edge while locked: one error, link stays up.
    l = {5}; push_n(l, 4, 20); l.push_back(2); push_n(l, 4, 5);
    run_sched("lock_early", l, 8, n_to);
    check("lock_early.locked_end", o_locked, 1);
    check("lock_early.cnt_end", o_err_cnt, 1);

    // Three bad edges keep lock, a fourth drops it.
    l = {5}; push_n(l, 4, 20); l.push_back(2); l.push_back(1); l.push_back(2); push_n(l, 4, 2);
    run_sched("glitch3", l, 8, n_to);
    check("glitch3.locked_end", o_locked, 1);
    check("glitch3.cnt_end", o_err_cnt, 3);
    l = {5}; push_n(l, 4, 20); l.push_back(2); l.push_back(1); l.push_back(2); l.push_back(1);
    push_n(l, 4, 2);
    run_sched("glitch4", l, 8, n_to);
    check("glitch4.locked_end", o_locked, 0);
    check("glitch4.cnt_end", o_err_cnt, 4);

    // Constant high for 20 bit times after lock.
    l = {5}; push_n(l, 4, 20);
    run_sched("runlen", l, 80, n_to);
    check("runlen.timeouts", n_to, 1);
    check("runlen.locked_end", o_locked, 0);

    // +/-1 clock jitter on every edge.
    l = {5};
    for (int i = 0; i < 30; i++) l.push_back(int'($urandom_range(3, 5)));
    run_sched("jitter", l, 8, n_to);
    check("jitter.locked_end", o_locked, 1);
    check("jitter.cnt_end", o_err_cnt, 0);

    // Asynchronous reset between clock edges.
    l = {5}; push_n(l, 4, 20); l.push_back(2); push_n(l, 4, 4);
    run_sched("pre_reset", l, 6, n_to);
    #2 i_res_n = 1'b0;
    #1;
    check("midrst.data",   o_RecoveryData, 0);
    check("midrst.en",     o_DataEn,       0);
    check("midrst.err",    o_err,          0);
    check("midrst.to",     o_timeout,      0);
    check("midrst.locked", o_locked,       0);
    check("midrst.cnt",    o_err_cnt,      0);

    // Random mix of good, jittered, bad, glitch and over-long runs.
    l = {5};
    total = 5;
    while (total < 2400) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      g = int'($urandom_range(3, 5));
      else if (r < 80) g = 4 * int'($urandom_range(2, 4)) + int'($urandom_range(0, 2)) - 1;
      else if (r < 88) g = int'($urandom_range(1, 2));
      else if (r < 93) g = int'($urandom_range(6, 7));
      else             g = 4 * MAX_RUN + int'($urandom_range(4, 12));
      l.push_back(g);
      total += g;
    end
    run_sched("rand", l, 30, n_to);

    // Error count saturation and clear priority: toggling every clock makes every edge a glitch.
    do_reset();
    for (int c = 0; c < 65560; c++) begin
      i_SerialData = ~i_SerialData;
      @(posedge i_clk);
      #1;
    end
    @(negedge i_clk);
    check("sat.cnt", o_err_cnt, 16'hFFFF);
    @(posedge i_clk);
    #1 i_SerialData = ~i_SerialData;
    @(negedge i_clk);
    check("sat.err_more", o_err, 1);
    check("sat.cnt_hold", o_err_cnt, 16'hFFFF);
    @(posedge i_clk);
    #1;
    i_SerialData = ~i_SerialData;
    i_err_clr = 1'b1;
    @(negedge i_clk);
    check("clr.err_coincident", o_err, 1);
    @(posedge i_clk);
    #1 i_err_clr = 1'b0;
    @(negedge i_clk);
    check("clr.cnt", o_err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
